// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: latches one load/store, waits WAIT_CYCLES, then pulses ready.
// Define DMEM_ERR_EN to add the error port with misaligned / out-of-range checking.
module dmem_responder #(
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [63:0] address,
    input  logic [63:0] write_data,
    output logic [63:0] read_data,
    output logic        ready
`ifdef DMEM_ERR_EN
    ,
    output logic        error
`endif
);
    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    logic [7:0]         r_cnt;
    logic               r_wr;
    logic               r_err;
    logic [IDX_W-1:0]   r_idx;
    logic [63:0]        r_wdata;
    logic [63:0]        r_read_data;
    logic               r_ready;
    logic               r_error;
    logic [63:0]        r_mem [DEPTH];

    logic               w_idle;
    logic               w_accept;
    logic               w_enter_resp;
    logic               w_wr;
    logic               w_err;
    logic               w_err_in;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_idx_in;
    logic [63:0]        w_wdata;

    assign w_idx_in = address[3 +: IDX_W];

`ifdef DMEM_ERR_EN
    assign w_err_in = (address[2:0] != 3'b000) || ((address >> (3 + IDX_W)) != 64'd0);
    assign error    = r_error;
`else
    logic w_unused;
    assign w_err_in = 1'b0;
    assign w_unused = ^{address[63:3+IDX_W], address[2:0], r_error};
`endif

    // In IDLE the operands come straight from the ports (needed by the zero-wait path);
    // once accepted, only the latched copies are used so input changes are ignored.
    assign w_idle       = (r_state == S_IDLE);
    assign w_accept     = w_idle && (mem_read || mem_write);
    assign w_enter_resp = (w_accept && ZERO_WAIT) || ((r_state == S_WAIT) && (r_cnt == 8'd1));
    assign w_wr         = w_idle ? mem_write  : r_wr;
    assign w_err        = w_idle ? w_err_in   : r_err;
    assign w_idx        = w_idle ? w_idx_in   : r_idx;
    assign w_wdata      = w_idle ? write_data : r_wdata;

    assign read_data = r_read_data;
    assign ready     = r_ready;

    always_ff @(posedge clk) begin
        if (w_enter_resp && w_wr && !w_err)
            r_mem[w_idx] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx   <= w_idx_in;
            r_wdata <= write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_wr        <= 1'b0;
            r_err       <= 1'b0;
            r_read_data <= 64'd0;
            r_ready     <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_ready <= w_enter_resp;
            if (w_enter_resp) begin
                r_error <= w_err;
                if (!w_wr)
                    r_read_data <= w_err ? 64'd0 : r_mem[w_idx];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_wr    <= mem_write;
                        r_err   <= w_err_in;
                        r_cnt   <= WAIT_INIT;
                        r_state <= ZERO_WAIT ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1)
                        r_state <= S_RESP;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the target end of the CPU's load/store interface (mem_read, mem_write, address, write_data).
- Answers each request after a programmable number of wait states and signals completion with a one-cycle ready pulse.
- Lets the core be moved off the zero-latency memory model toward pipelined and stalling datapaths.
- Storage is an array of 64-bit doublewords; the address is a byte address.

Parameters:
- DEPTH, 128, number of 64-bit doublewords stored (power of two).
- WAIT_CYCLES, 2, wait states between request acceptance and the ready pulse (0..255).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- mem_read  input  1  load request.
- mem_write  input  1  store request.
- address  input  64  byte address.
- write_data  input  64  store data.
- read_data  output  64  load data; valid while ready=1 for a read.
- ready  output  1  one-cycle completion pulse.
- error  output  1  completion status (DMEM_ERR_EN only); valid while ready=1.

Behaviour:
- Reset (async): state=IDLE, ready=0, read_data=0, error=0, wait counter=0.
  - Array contents are not cleared.
  - Any pending write is abandoned and never committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read or mem_write is 1 at a rising edge, the request is accepted.
  - At acceptance, the responder latches op, address and write_data, and loads counter=WAIT_CYCLES.
  - Next state is WAIT, or RESP directly when WAIT_CYCLES=0.
- Simultaneous mem_read and mem_write: treated as a write.
- WAIT:
  - The counter decrements each cycle.
  - Input changes are ignored, because the latched copies are used.
  - When the counter reaches 1, the next edge enters RESP.
- Entering RESP (the clock edge):
  - A valid write commits to the array at that edge.
  - A read captures array[index] into read_data at that edge.
- RESP:
  - ready=1 for exactly one cycle.
  - read_data holds its value until the next read completes; writes do not alter it.
  - Next state is always IDLE.
- Latency: request sampled at edge T gives ready high during cycle T+WAIT_CYCLES+1.
  - Requests are not accepted in RESP.
  - Maximum throughput is one request per WAIT_CYCLES+2 cycles.
- Requester rules:
  - The requester holds its request until it sees ready.
  - It must drop the request, or present a new one, in the cycle after ready.
- Index: index = address[3+log2(DEPTH)-1:3].
- Read-after-write to the same address in consecutive transactions returns the new data.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined: the error port exists, and error=1 with ready for any of these:
  - misaligned access (address[2:0] != 0);
  - out-of-range access (address >= DEPTH*8).
- Effect of an errored access:
  - A write is dropped, leaving the array unchanged.
  - A read returns read_data=0.
- Undefined:
  - The error port is absent.
  - address[2:0] are ignored, so a misaligned access goes to the containing doubleword.
  - Upper address bits are ignored, so the index wraps modulo DEPTH.

Test Plan:
- Reset: assert reset mid-run -> ready=0, read_data=0, error=0 immediately, without waiting for a clock edge.
- Round trip (WAIT_CYCLES=2):
  - Write 0x00000000DEADBEEF to 0x10 at edge T -> ready at T+3.
  - Then read 0x10 -> ready 3 cycles after acceptance, read_data=0x00000000DEADBEEF.
- Input hold (WAIT_CYCLES=2):
  - Read 0x10, then change address to 0x18 during WAIT -> read_data still equals the contents of 0x10.
- Zero wait (WAIT_CYCLES=0):
  - Write 0x1234 to 0x08 at edge T -> ready during T+1.
  - Back-to-back read of 0x08 accepted at T+2 -> ready at T+3, read_data=0x1234.
- Errors (DMEM_ERR_EN defined):
  - Write to 0x13 -> error=1 and the contents of 0x10 are unchanged.
  - Read 0x400 -> error=1, read_data=0.
  - Same test with the macro undefined -> read 0x400 returns the contents of 0x000.
- Reset during a write:
  - Write 0xAA to 0x20, assert reset during WAIT, release, then read 0x20 -> the pre-write value (not 0xAA), and no stray ready pulse.
